// File: rtl/mem_fill_verify.sv
// mem_fill_verify
//   Fills a single-port synchronous RAM with a selectable pattern. It can then
//   read every word back and check it against the same pattern. This block owns
//   the RAM bus until done, and then hands the memory to the next stage.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   run request; the block acts on its 0->1 edge only
//   mode, fill_value        pattern select and seed; latched when a run is accepted
//   verify_en               add a readback pass after the fill; latched when a run is accepted
//   mem_address/mem_data/mem_wren   RAM request (all registered)
//   mem_q                   RAM read data, valid READ_LAT cycles after mem_address
//   busy                    high through FILL, VERIFY and DRAIN
//   done                    one-cycle completion pulse
//   error/err_count/fail_addr  sticky mismatch flag, saturating count, first bad address
//
// Pattern for address a (fv = latched fill_value):
//   00: a   01: fv   10: ~a   11: fv + a   (all truncated/extended to DATA_W)
module mem_fill_verify #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              verify_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_VERIFY,
    S_DRAIN,
    S_DONE
  } state_e;

  // The end of a pass is detected by comparing against the terminal count.
  // This also works when DEPTH == 2**ADDR_W, because the counter never has to
  // reach DEPTH.
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(READ_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] fv,
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] aw;
    aw = DATA_W'(a);
    case (m)
      2'b00:   pattern = aw;
      2'b01:   pattern = fv;
      2'b10:   pattern = ~aw;
      default: pattern = fv + aw;
    endcase
  endfunction

  state_e                          state_q, state_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [DATA_W-1:0]               data_q, data_d;
  logic                            wren_q, wren_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            error_q, error_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [ADDR_W-1:0]               fail_q, fail_d;
  logic [1:0]                      mode_q, mode_d;
  logic [DATA_W-1:0]               fv_q, fv_d;
  logic                            ven_q, ven_d;
  logic                            start_q, start_d;
  logic [1:0]                      drain_q, drain_d;
  // Read-tracking pipeline. Stage k holds the read that was issued k cycles ago.
  // The last stage lines up with the returning mem_q.
  logic [READ_LAT:1]               vld_pipe_q, vld_pipe_d;
  logic [READ_LAT:1][ADDR_W-1:0]   apipe_q, apipe_d;

  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mismatch;
  logic              accept;

  assign addr_inc = addr_q + ADDR_W'(1);
  assign cmp_addr = apipe_q[READ_LAT];
  assign mismatch = vld_pipe_q[READ_LAT] && (mem_q != pattern(mode_q, fv_q, cmp_addr));
  assign accept   = (state_q == S_IDLE) && start && !start_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = '0;
    wren_d  = 1'b0;
    error_d = error_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    mode_d  = mode_q;
    fv_d    = fv_q;
    ven_d   = ven_q;
    drain_d = drain_q;
    start_d = start;

    // While a read is being issued, addr_q is that read's address. Outside
    // VERIFY the pipeline shifts in bubbles.
    vld_pipe_d    = '0;
    apipe_d       = '0;
    vld_pipe_d[1] = (state_q == S_VERIFY);
    apipe_d[1]    = addr_q;
    for (int k = 2; k <= READ_LAT; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      apipe_d[k]    = apipe_q[k-1];
    end

    // Compare results go in before the state case. That way a clear on an
    // accepted start always wins; the pipeline is empty in IDLE anyway.
    if (mismatch) begin
      error_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (!error_q) fail_d = cmp_addr;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d  = mode;
          fv_d    = fill_value;
          ven_d   = verify_en;
          error_d = 1'b0;
          cnt_d   = '0;
          fail_d  = '0;
          state_d = S_FILL;
          addr_d  = '0;
          wren_d  = 1'b1;
          data_d  = pattern(mode, fill_value, '0);
        end
      end
      S_FILL: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = ven_q ? S_VERIFY : S_DONE;
        end else begin
          addr_d = addr_inc;
          wren_d = 1'b1;
          data_d = pattern(mode_q, fv_q, addr_inc);
        end
      end
      S_VERIFY: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_inc;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
        else                       drain_d = drain_q + 2'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FILL) || (state_d == S_VERIFY) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      wren_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
      fail_q     <= '0;
      mode_q     <= '0;
      fv_q       <= '0;
      ven_q      <= 1'b0;
      // Resetting to 1 means a start held high through reset is not seen as an edge.
      start_q    <= 1'b1;
      drain_q    <= '0;
      vld_pipe_q <= '0;
      apipe_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wren_q     <= wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      mode_q     <= mode_d;
      fv_q       <= fv_d;
      ven_q      <= ven_d;
      start_q    <= start_d;
      drain_q    <= drain_d;
      vld_pipe_q <= vld_pipe_d;
      apipe_q    <= apipe_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_wren    = wren_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_count   = cnt_q;
  assign fail_addr   = fail_q;

endmodule

// File: tb/tb_mem_fill_verify.sv
// Testbench for mem_fill_verify.
//   dut0: default parameters, with a RAM model that has one cycle of read latency.
//   dut1: DEPTH=200, READ_LAT=2 and CNT_W=2 (to reach saturation), with a
//         RAM model that has two cycles of read latency.
// Expected writes are queued as each run is started, then popped as the DUT
// drives them.
module tb_mem_fill_verify;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       start0, ven0, wren0, busy0, done0, error0;
  logic [1:0] mode0;
  logic [7:0] fv0, addr0, data0, q0, fail0;
  logic [8:0] cnt0;

  logic       start1, ven1, wren1, busy1, done1, error1;
  logic [1:0] mode1;
  logic [7:0] fv1, addr1, data1, q1, q1a, fail1;
  logic [1:0] cnt1;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic corrupt0 = 1'b0;
  logic corrupt1 = 1'b0;
  logic [7:0] ram0 [256];
  logic [7:0] ram1 [256];

  mem_fill_verify u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .mode(mode0), .fill_value(fv0),
    .verify_en(ven0), .mem_address(addr0), .mem_data(data0), .mem_wren(wren0),
    .mem_q(q0), .busy(busy0), .done(done0), .error(error0), .err_count(cnt0),
    .fail_addr(fail0)
  );

  mem_fill_verify #(.DEPTH(200), .READ_LAT(2), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode1), .fill_value(fv1),
    .verify_en(ven1), .mem_address(addr1), .mem_data(data1), .mem_wren(wren1),
    .mem_q(q1), .busy(busy1), .done(done1), .error(error1), .err_count(cnt1),
    .fail_addr(fail1)
  );

  // RAM models; the corrupt flags flip read data at chosen addresses
  always @(posedge clk) begin
    if (wren0) ram0[addr0] <= data0;
    q0 <= ram0[addr0] ^ ((corrupt0 && (addr0 == 8'h21 || addr0 == 8'h80)) ? 8'h01 : 8'h00);
  end

  always @(posedge clk) begin
    if (wren1) ram1[addr1] <= data1;
    q1a <= ram1[addr1] ^ ((corrupt1 && addr1 >= 8'h05) ? 8'h80 : 8'h00);
    q1  <= q1a;
  end

  function automatic logic [7:0] pat(input logic [1:0] m, input logic [7:0] fv, input int a);
    logic [7:0] a8;
    a8 = 8'(a);
    case (m)
      2'b00:   return a8;
      2'b01:   return fv;
      2'b10:   return ~a8;
      default: return 8'(fv + a8);
    endcase
  endfunction

  // Pulses start; returns on the negedge after the accepting edge (cycle 0).
  // The pattern inputs are then scrambled so that the test shows they were latched.
  task automatic start_dut(input int which, input logic [1:0] m, input logic [7:0] fv,
                           input logic ven);
    @(negedge clk);
    if (which == 0) begin mode0 = m; fv0 = fv; ven0 = ven; start0 = 1'b1; end
    else            begin mode1 = m; fv1 = fv; ven1 = ven; start1 = 1'b1; end
    @(negedge clk);
    if (which == 0) begin start0 = 1'b0; mode0 = ~m; fv0 = ~fv; ven0 = ~ven; end
    else            begin start1 = 1'b0; mode1 = ~m; fv1 = ~fv; ven1 = ~ven; end
  endtask

  task automatic wait_done(input int which, input int max, output int n);
    n = 0;
    while (((which == 0) ? done0 : done1) !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    mode0 = 2'b00; fv0 = 8'h00; ven0 = 1'b0;
    mode1 = 2'b00; fv1 = 8'h00; ven1 = 1'b0;
    #12;
    checks++;
    if ({addr0, data0, wren0, busy0, done0, error0, cnt0, fail0} !== '0) begin
      failures++;
      $display("FAIL reset_dut0 got=%h want=0", {addr0, data0, wren0, busy0, done0, error0, cnt0, fail0});
    end
    checks++;
    if ({addr1, data1, wren1, busy1, done1, error1, cnt1, fail1} !== '0) begin
      failures++;
      $display("FAIL reset_dut1 got=%h want=0", {addr1, data1, wren1, busy1, done1, error1, cnt1, fail1});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fill_only();
    logic [15:0] e;
    int done_at;
    exp_q.delete();
    for (int a = 0; a < 256; a++) exp_q.push_back({8'(a), pat(2'b00, 8'h3C, a)});
    start_dut(0, 2'b00, 8'h3C, 1'b0);
    done_at = -1;
    for (int n = 0; n < 600 && done_at < 0; n++) begin
      if (wren0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL fill_only_extra_write got=%h", {addr0, data0});
        end else begin
          e = exp_q.pop_front();
          if ({addr0, data0} !== e) begin
            failures++; $display("FAIL fill_only_write got=%h want=%h", {addr0, data0}, e);
          end
        end
      end
      if (done0) done_at = n;
      else @(negedge clk);
    end
    checks++;
    if (done_at !== 256) begin failures++; $display("FAIL fill_only_done_cycle got=%0d want=256", done_at); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL fill_only_missing_writes got=%0d want=0", exp_q.size()); end
    checks++;
    if ({error0, cnt0} !== '0) begin failures++; $display("FAIL fill_only_error got=%h want=0", {error0, cnt0}); end
  endtask

  task automatic test_fill_verify(input logic corrupt);
    logic [15:0] e;
    int done_at, rd;
    corrupt0 = corrupt;
    exp_q.delete();
    for (int a = 0; a < 256; a++) exp_q.push_back({8'(a), pat(2'b11, 8'hF0, a)});
    start_dut(0, 2'b11, 8'hF0, 1'b1);
    done_at = -1; rd = 0;
    for (int n = 0; n < 700 && done_at < 0; n++) begin
      if (wren0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL verify_extra_write got=%h", {addr0, data0});
        end else begin
          e = exp_q.pop_front();
          if ({addr0, data0} !== e) begin
            failures++; $display("FAIL verify_write got=%h want=%h", {addr0, data0}, e);
          end
        end
      end else if (busy0) rd++;
      if (done0) done_at = n;
      else @(negedge clk);
    end
    corrupt0 = 1'b0;
    checks++;
    if (ram0[8'h10] !== 8'h00) begin failures++; $display("FAIL verify_wrap_mem10 got=%h want=00", ram0[8'h10]); end
    checks++;
    if (done_at !== 513) begin failures++; $display("FAIL verify_done_cycle got=%0d want=513", done_at); end
    checks++;
    if (rd !== 257) begin failures++; $display("FAIL verify_read_cycles got=%0d want=257", rd); end
    checks++;
    if (error0 !== corrupt) begin failures++; $display("FAIL verify_error got=%b want=%b", error0, corrupt); end
    checks++;
    if (cnt0 !== (corrupt ? 9'd2 : 9'd0)) begin failures++; $display("FAIL verify_err_count got=%0d want=%0d", cnt0, corrupt ? 2 : 0); end
    checks++;
    if (fail0 !== (corrupt ? 8'h21 : 8'h00)) begin failures++; $display("FAIL verify_fail_addr got=%h want=%h", fail0, corrupt ? 8'h21 : 8'h00); end
  endtask

  task automatic test_error_clear();
    int n;
    start_dut(0, 2'b01, 8'h11, 1'b0);
    checks++;
    if ({error0, cnt0, fail0} !== '0) begin failures++; $display("FAIL clear_on_start got=%h want=0", {error0, cnt0, fail0}); end
    wait_done(0, 300, n);
    checks++;
    if (done0 !== 1'b1) begin failures++; $display("FAIL clear_run_done got=%b want=1", done0); end
  endtask

  task automatic test_start_ignore();
    logic [15:0] e;
    int cnt, nbusy, done_at;
    @(negedge clk);
    start0 = 1'b1; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (busy0 || wren0) cnt++; end
    checks++;
    if (cnt !== 0) begin failures++; $display("FAIL start_through_reset busy_cycles got=%0d want=0", cnt); end
    start0 = 1'b0;
    exp_q.delete();
    for (int a = 0; a < 256; a++) exp_q.push_back({8'(a), pat(2'b01, 8'hA5, a)});
    start_dut(0, 2'b01, 8'hA5, 1'b0);
    nbusy = 0; done_at = -1;
    for (int n = 0; n < 600 && done_at < 0; n++) begin
      if (n == 50 || n == 100) start0 = 1'b1;
      if (n == 60 || n == 101) start0 = 1'b0;
      if (busy0) nbusy++;
      if (wren0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL ignore_extra_write got=%h", {addr0, data0});
        end else begin
          e = exp_q.pop_front();
          if ({addr0, data0} !== e) begin
            failures++; $display("FAIL ignore_write got=%h want=%h", {addr0, data0}, e);
          end
        end
      end
      if (done0) done_at = n;
      else @(negedge clk);
    end
    // A start edge that arrives while done is high must also be ignored
    start0 = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (busy0) cnt++; end
    start0 = 1'b0;
    checks++;
    if (nbusy !== 256) begin failures++; $display("FAIL ignore_busy_cycles got=%0d want=256", nbusy); end
    checks++;
    if (done_at !== 256) begin failures++; $display("FAIL ignore_done_cycle got=%0d want=256", done_at); end
    checks++;
    if (cnt !== 0) begin failures++; $display("FAIL start_in_done busy_cycles got=%0d want=0", cnt); end
  endtask

  task automatic test_async_reset();
    int n;
    start_dut(0, 2'b00, 8'h00, 1'b0);
    n = 0;
    while (addr0 !== 8'h40 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (n !== 64 || wren0 !== 1'b1) begin failures++; $display("FAIL areset_reach_40 got=%0d/%b want=64/1", n, wren0); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({wren0, busy0} !== 2'b00) begin failures++; $display("FAIL areset_immediate got=%b want=00", {wren0, busy0}); end
    @(negedge clk);
    reset_n = 1'b1;
    start_dut(0, 2'b00, 8'h00, 1'b0);
    checks++;
    if ({wren0, addr0, data0} !== {1'b1, 8'h00, 8'h00}) begin
      failures++; $display("FAIL refill_first got=%h want=10000", {wren0, addr0, data0});
    end
    @(negedge clk);
    checks++;
    if ({wren0, addr0, data0} !== {1'b1, 8'h01, 8'h01}) begin
      failures++; $display("FAIL refill_second got=%h want=10101", {wren0, addr0, data0});
    end
    wait_done(0, 300, n);
    checks++;
    if (done0 !== 1'b1) begin failures++; $display("FAIL refill_done got=%b want=1", done0); end
  endtask

  task automatic test_depth200();
    logic [15:0] e, last_wr;
    int done_at, rd, n;
    exp_q.delete();
    for (int a = 0; a < 200; a++) exp_q.push_back({8'(a), pat(2'b10, 8'h00, a)});
    start_dut(1, 2'b10, 8'h00, 1'b1);
    done_at = -1; rd = 0; last_wr = '0;
    for (int k = 0; k < 600 && done_at < 0; k++) begin
      if (wren1) begin
        last_wr = {addr1, data1};
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL d200_extra_write got=%h", {addr1, data1});
        end else begin
          e = exp_q.pop_front();
          if ({addr1, data1} !== e) begin
            failures++; $display("FAIL d200_write got=%h want=%h", {addr1, data1}, e);
          end
        end
      end else if (busy1) rd++;
      if (done1) done_at = k;
      else @(negedge clk);
    end
    checks++;
    if (last_wr !== 16'hC738) begin failures++; $display("FAIL d200_last_write got=%h want=c738", last_wr); end
    checks++;
    if (done_at !== 402) begin failures++; $display("FAIL d200_done_cycle got=%0d want=402", done_at); end
    checks++;
    if (rd !== 202) begin failures++; $display("FAIL d200_verify_drain_cycles got=%0d want=202", rd); end
    checks++;
    if ({error1, cnt1, fail1} !== '0) begin failures++; $display("FAIL d200_clean_error got=%h want=0", {error1, cnt1, fail1}); end
    // Corrupt reads from address 5 upward: the count saturates and the first failing address is kept
    corrupt1 = 1'b1;
    start_dut(1, 2'b10, 8'h00, 1'b1);
    wait_done(1, 600, n);
    corrupt1 = 1'b0;
    checks++;
    if (n !== 402) begin failures++; $display("FAIL d200_corrupt_done got=%0d want=402", n); end
    checks++;
    if ({error1, cnt1, fail1} !== {1'b1, 2'b11, 8'h05}) begin
      failures++; $display("FAIL d200_corrupt_error got=%h want=%h", {error1, cnt1, fail1}, {1'b1, 2'b11, 8'h05});
    end
    @(negedge clk);
    checks++;
    if ({error1, cnt1, fail1} !== {1'b1, 2'b11, 8'h05}) begin
      failures++; $display("FAIL d200_error_hold got=%h want=%h", {error1, cnt1, fail1}, {1'b1, 2'b11, 8'h05});
    end
    start_dut(1, 2'b01, 8'h77, 1'b0);
    checks++;
    if ({error1, cnt1, fail1} !== '0) begin failures++; $display("FAIL d200_clear got=%h want=0", {error1, cnt1, fail1}); end
    wait_done(1, 300, n);
    checks++;
    if (n !== 200) begin failures++; $display("FAIL d200_fill_only_done got=%0d want=200", n); end
  endtask

  initial begin
    test_reset();
    test_fill_only();
    test_fill_verify(1'b0);
    test_fill_verify(1'b1);
    test_error_clear();
    test_start_ignore();
    test_async_reset();
    test_depth200();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_fill_verify.md
Name: mem_fill_verify

Overview:
- Parametrised successor to the RAM populate counter.
- On a start request, writes a selectable data pattern to every location of a single-port synchronous RAM (the s_memory class).
- Can then read the whole RAM back and compare each word against the same pattern, reporting a sticky error flag, a mismatch count and the first failing address.
- Sits between the top level and the working-memory RAM; runs before any consumer of the RAM (e.g. a swap/KSA stage) takes over the memory bus.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 256, number of words filled/verified; legal range 1 to 2**ADDR_W.
- READ_LAT, 1, cycles from a driven mem_address to the matching valid mem_q; legal range 1 to 3.
- CNT_W, 9, width of err_count; the counter saturates.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; rising-edge detected internally.
- mode  in  2  pattern select; latched at start.
- fill_value  in  DATA_W  constant or seed for the pattern; latched at start.
- verify_en  in  1  run the readback pass after the fill; latched at start.
- mem_address  out  ADDR_W  RAM address.
- mem_data  out  DATA_W  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_q  in  DATA_W  RAM read data.
- busy  out  1  high in FILL, VERIFY and DRAIN.
- done  out  1  one-cycle pulse at completion.
- error  out  1  sticky mismatch flag; cleared at the next accepted start.
- err_count  out  CNT_W  number of mismatches, saturating at all-ones.
- fail_addr  out  ADDR_W  address of the first mismatch; valid while error=1.

Behaviour:
- Reset values (asynchronous, while reset_n=0):
  - state=IDLE; all outputs 0; internal start_q=1.
  - A start held high through reset does not trigger a run; start must go 0 then 1.
- Pattern for address a, with fv = the latched fill_value:
  - mode 00: a[DATA_W-1:0], zero-extended if DATA_W>ADDR_W.
  - mode 01: fv.
  - mode 10: ~a[DATA_W-1:0].
  - mode 11: (fv + a) mod 2**DATA_W.
- All outputs are registered.
- IDLE:
  - On a clock edge with start=1 and start_q=0: latch mode, fill_value and verify_en; clear error, err_count and fail_addr; go to FILL with mem_address=0 and mem_wren=1.
  - Any other start value is ignored.
- FILL:
  - One write per cycle: mem_address = 0..DEPTH-1 with mem_data = pattern(mem_address); exactly DEPTH cycles with mem_wren=1.
  - After address DEPTH-1: if verify_en is latched, go to VERIFY with mem_address=0 and mem_wren=0. Otherwise go to DONE.
- VERIFY:
  - Issues one read per cycle, addresses 0..DEPTH-1, with mem_wren=0 and mem_data=0.
  - A READ_LAT-deep shift pipeline carries the issued address plus a valid bit.
  - When the valid bit reaches the pipeline output, compare mem_q against pattern(that address).
  - On a mismatch: increment err_count (saturating); set error; capture fail_addr only if error was 0.
  - After the last issue, go to DRAIN.
- DRAIN:
  - Exactly READ_LAT cycles to retire the outstanding compares, then go to DONE.
- DONE:
  - done=1 and busy=0 for one cycle, then IDLE.
  - error, err_count and fail_addr hold until the next accepted start.
- Cycle totals from the accepting edge to the done pulse:
  - Fill only: DEPTH cycles, then done.
  - With verify: 2*DEPTH + READ_LAT cycles, then done.
- start edges seen while busy or in DONE are ignored; start_q still tracks start.
- Address counter wrap: when DEPTH=2**ADDR_W, the end-of-pass test uses the terminal count, not an overflow compare, so the counter never runs past DEPTH-1.
- Reset mid-run: mem_wren drops to 0 immediately (asynchronously) and the state returns to IDLE. Partial RAM contents are not restored.

Test Plan:
1. Default parameters, mode=00, verify_en=0, pulse start → 256 consecutive writes mem[i]=i with mem_wren=1; done pulses on cycle 256 after acceptance; error=0.
2. mode=11, fill_value=8'hF0, verify_en=1, RAM model with READ_LAT=1 → writes mem[0x10]=0x00 (wraps); verify finds no mismatch; done on cycle 513; err_count=0.
3. Same as 2, but the RAM model corrupts reads of 0x21 and 0x80 → error=1, err_count=2, fail_addr=0x21.
4. Hold start high through reset release → no run starts. Raise start during FILL → ignored; busy stays high for exactly 256 cycles.
5. Assert reset_n=0 at fill address 0x40 → mem_wren=0 and busy=0 without waiting for a clock edge. A new start then refills from address 0.
6. DEPTH=200, READ_LAT=2, mode=10, verify on a correct RAM → last write at address 199 with data 0x38; DRAIN lasts 2 cycles; done pulses at cycle 402; then a second start clears the error fields.
